// File: rtl/next_pc_unit.sv
// next_pc_unit: PC register with prioritised jr/jump/branch redirects, stall parking,
// misaligned-target trap to an exception vector and a saturating redirect counter.
module next_pc_unit #(
    parameter int PC_W = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'('h180),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [15:0]      branch_imm,
    input  logic             jump_en,
    input  logic [25:0]      jump_index,
    input  logic             jr_en,
    input  logic [PC_W-1:0]  jr_target,
    input  logic [PC_W-1:0]  id_pc_plus4,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus4,
    output logic             flush,
    output logic             addr_err,
    output logic [PC_W-1:0]  bad_addr,
    output logic [CNT_W-1:0] redirect_count
);
    logic [PC_W-1:0] bta, jta, req_target, apply_target, pend_target;
    logic            req, pend_valid, misaligned;

    assign pc_plus4     = pc + PC_W'(4);
    assign bta          = id_pc_plus4 + {{(PC_W-18){branch_imm[15]}}, branch_imm, 2'b00};
    assign jta          = {id_pc_plus4[PC_W-1:28], jump_index, 2'b00};
    assign req          = jr_en | jump_en | branch_taken;
    assign req_target   = jr_en ? jr_target : jump_en ? jta : bta;
    // A live request beats a parked one; alignment is judged only at apply time.
    assign apply_target = req ? req_target : pend_target;
    assign misaligned   = |apply_target[1:0];
    assign flush        = !stall && (req || pend_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            pend_valid     <= 1'b0;
            pend_target    <= '0;
            addr_err       <= 1'b0;
            bad_addr       <= '0;
            redirect_count <= '0;
        end else if (stall) begin
            addr_err <= 1'b0;
            if (req) begin
                pend_valid  <= 1'b1;
                pend_target <= req_target;
            end
        end else if (flush) begin
            pc             <= misaligned ? EXC_VECTOR : apply_target;
            pend_valid     <= 1'b0;
            addr_err       <= misaligned;
            if (misaligned) bad_addr <= apply_target;
            if (redirect_count != '1) redirect_count <= redirect_count + CNT_W'(1);
        end else begin
            pc       <= pc_plus4;
            addr_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: directed vector table plus a reset-during-stall sequence for next_pc_unit.
module tb_next_pc_unit;
    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0;
    logic        branch_taken = 1'b0, jump_en = 1'b0, jr_en = 1'b0;
    logic [15:0] branch_imm = '0;
    logic [25:0] jump_index = '0;
    logic [31:0] jr_target = '0, id_pc_plus4 = '0;
    logic [31:0] pc, pc_plus4, bad_addr;
    logic        flush, addr_err;
    logic [1:0]  redirect_count;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    next_pc_unit #(.PC_W(32), .RESET_PC('0), .EXC_VECTOR(32'h180), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_imm(branch_imm), .jump_en(jump_en), .jump_index(jump_index),
        .jr_en(jr_en), .jr_target(jr_target), .id_pc_plus4(id_pc_plus4),
        .pc(pc), .pc_plus4(pc_plus4), .flush(flush), .addr_err(addr_err),
        .bad_addr(bad_addr), .redirect_count(redirect_count)
    );

    typedef struct {
        logic        stall, br, j, jr;
        logic [15:0] imm;
        logic [25:0] jidx;
        logic [31:0] jrt, idpc;
        logic        e_flush;
        logic [31:0] e_pc;
        logic [1:0]  e_cnt;
        logic        e_ae;
        logic [31:0] e_bad;
    } vec_t;

    function automatic vec_t v(logic s, logic br, logic j, logic jr, logic [15:0] imm,
                               logic [25:0] jidx, logic [31:0] jrt, logic [31:0] idpc,
                               logic ef, logic [31:0] ep, logic [1:0] ec, logic ea,
                               logic [31:0] eb);
        vec_t r;
        r.stall = s; r.br = br; r.j = j; r.jr = jr; r.imm = imm; r.jidx = jidx;
        r.jrt = jrt; r.idpc = idpc; r.e_flush = ef; r.e_pc = ep; r.e_cnt = ec;
        r.e_ae = ea; r.e_bad = eb;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t x);
        stall = x.stall; branch_taken = x.br; jump_en = x.j; jr_en = x.jr;
        branch_imm = x.imm; jump_index = x.jidx; jr_target = x.jrt; id_pc_plus4 = x.idpc;
    endtask

    vec_t vecs[20];

    initial begin
        //             s  br j  jr imm       jidx    jrt           idpc          fl pc            cnt ae bad
        vecs[0]  = v(0, 0, 0, 0, 16'h0,    26'h0,  32'h0,        32'h0,        0, 32'h4,        0, 0, 32'h0);
        vecs[1]  = v(0, 0, 0, 0, 16'h0,    26'h0,  32'h0,        32'h0,        0, 32'h8,        0, 0, 32'h0);
        vecs[2]  = v(0, 0, 0, 0, 16'h0,    26'h0,  32'h0,        32'h0,        0, 32'hC,        0, 0, 32'h0);
        vecs[3]  = v(0, 1, 0, 0, 16'hFFFE, 26'h0,  32'h0,        32'h100,      1, 32'hF8,       1, 0, 32'h0);
        vecs[4]  = v(0, 1, 1, 1, 16'h1,    26'h40, 32'h400,      32'h1000_0000,1, 32'h400,      2, 0, 32'h0);
        vecs[5]  = v(1, 0, 1, 0, 16'h0,    26'h40, 32'h0,        32'h1000_0000,0, 32'h400,      2, 0, 32'h0);
        vecs[6]  = v(1, 0, 0, 0, 16'h0,    26'h0,  32'h0,        32'h0,        0, 32'h400,      2, 0, 32'h0);
        vecs[7]  = v(1, 0, 0, 0, 16'h0,    26'h0,  32'h0,        32'h0,        0, 32'h400,      2, 0, 32'h0);
        vecs[8]  = v(0, 0, 0, 0, 16'h0,    26'h0,  32'h0,        32'h0,        1, 32'h1000_0100,3, 0, 32'h0);
        vecs[9]  = v(0, 0, 0, 0, 16'h0,    26'h0,  32'h0,        32'h0,        0, 32'h1000_0104,3, 0, 32'h0);
        vecs[10] = v(0, 0, 0, 1, 16'h0,    26'h0,  32'h203,      32'h0,        1, 32'h180,      3, 1, 32'h203);
        vecs[11] = v(0, 0, 0, 0, 16'h0,    26'h0,  32'h0,        32'h0,        0, 32'h184,      3, 0, 32'h203);
        vecs[12] = v(1, 0, 0, 1, 16'h0,    26'h0,  32'h500,      32'h0,        0, 32'h184,      3, 0, 32'h203);
        vecs[13] = v(1, 1, 0, 0, 16'h4,    26'h0,  32'h0,        32'h200,      0, 32'h184,      3, 0, 32'h203);
        vecs[14] = v(0, 0, 1, 0, 16'h0,    26'h10, 32'h0,        32'h0,        1, 32'h40,       3, 0, 32'h203);
        vecs[15] = v(0, 0, 0, 0, 16'h0,    26'h0,  32'h0,        32'h0,        0, 32'h44,       3, 0, 32'h203);
        vecs[16] = v(1, 0, 0, 1, 16'h0,    26'h0,  32'h302,      32'h0,        0, 32'h44,       3, 0, 32'h203);
        vecs[17] = v(0, 0, 0, 0, 16'h0,    26'h0,  32'h0,        32'h0,        1, 32'h180,      3, 1, 32'h302);
        vecs[18] = v(0, 0, 0, 1, 16'h0,    26'h0,  32'hFFFF_FFFC,32'h0,        1, 32'hFFFF_FFFC,3, 0, 32'h302);
        vecs[19] = v(0, 0, 0, 0, 16'h0,    26'h0,  32'h0,        32'h0,        0, 32'h0,        3, 0, 32'h302);

        @(posedge clk); @(posedge clk); #1;
        chk("reset pc", pc, 32'h0);
        chk("reset cnt", 32'(redirect_count), 32'h0);
        chk("reset addr_err", 32'(addr_err), 32'h0);
        chk("reset bad_addr", bad_addr, 32'h0);
        chk("reset pc_plus4", pc_plus4, 32'h4);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].e_flush));
            @(posedge clk); #1;
            chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d cnt", i), 32'(redirect_count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d addr_err", i), 32'(addr_err), 32'(vecs[i].e_ae));
            chk($sformatf("v%0d bad_addr", i), bad_addr, vecs[i].e_bad);
        end

        // Park a redirect under stall, then reset while still stalled: it must vanish.
        drive(v(1, 0, 0, 1, 16'h0, 26'h0, 32'h800, 32'h0, 0, 32'h0, 0, 0, 32'h0));
        @(posedge clk); #1;
        chk("park pc hold", pc, 32'h0);
        drive(v(1, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst pc", pc, 32'h0);
        chk("rst cnt", 32'(redirect_count), 32'h0);
        chk("rst bad_addr", bad_addr, 32'h0);
        stall = 1'b0;
        #1;
        chk("rst pend flush", 32'(flush), 32'h0);
        @(posedge clk); #1;
        chk("rst pend pc", pc, 32'h4);
        chk("rst pend cnt", 32'(redirect_count), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
